// File: rtl/slice_decode_sequencer.sv
// slice_decode_sequencer: steps one slice through the DC VLD, drain, AC VLD and IDCT phases.
// Every output is a flop, loaded from the next-state value so it is valid in a state's first cycle.
module slice_decode_sequencer #(
   parameter int DC_VLD_LAT = 2,
   parameter int IDCT_TIME  = 12
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        slice_start,
   input  logic [31:0] block_num,
   input  logic        ac_vld_done,
   output logic        busy,
   output logic        dc_vld_enable,
   output logic [31:0] dc_vld_counter,
   output logic        ac_vld_enable,
   output logic [31:0] ac_vld_counter,
   output logic        idct_enable,
   output logic [31:0] idct_counter,
   output logic        slice_done,
   output logic        slice_overrun,
   output logic        ac_timeout,
   output logic [31:0] sequence_counter
);
   typedef enum logic [2:0] {IDLE, DC, DC_DRAIN, AC, IDCT, DONE} state_t;
   localparam logic [31:0] DRAIN_LAST = 32'(DC_VLD_LAT - 1);
   state_t      state_q, state_d;
   logic [31:0] nb_q, nb_d;
   logic [31:0] drain_q, drain_d;
   logic [31:0] dc_cnt_q, dc_cnt_d;
   logic [31:0] ac_cnt_q, ac_cnt_d;
   logic [31:0] idct_cnt_q, idct_cnt_d;
   logic [31:0] seq_q, seq_d;
   logic        busy_q, busy_d;
   logic        dc_en_q, dc_en_d;
   logic        ac_en_q, ac_en_d;
   logic        idct_en_q, idct_en_d;
   logic        done_q, done_d;
   logic        ovr_q, ovr_d;
   logic        tmo_q, tmo_d;
   logic [31:0] ac_last, idct_last;
   assign ac_last   = nb_q * 32'd63 - 32'd1;
   assign idct_last = nb_q + 32'(IDCT_TIME) - 32'd1;
   always_comb begin
      state_d = state_q;
      nb_d    = nb_q;
      tmo_d   = tmo_q;
      ovr_d   = slice_start && (state_q != IDLE || block_num == 32'd0);
      case (state_q)
         IDLE: if (slice_start && block_num != 32'd0) begin
            state_d = DC;
            nb_d    = block_num;
            tmo_d   = 1'b0;
         end
         DC:       if (dc_cnt_q == nb_q - 32'd1) state_d = (DC_VLD_LAT == 0) ? AC : DC_DRAIN;
         DC_DRAIN: if (drain_q == DRAIN_LAST) state_d = AC;
         // ac_vld_done takes priority over the timeout on the same cycle
         AC: if (ac_vld_done) state_d = IDCT;
            else if (ac_cnt_q == ac_last) begin
               state_d = IDCT;
               tmo_d   = 1'b1;
            end
         IDCT:    if (idct_cnt_q == idct_last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d     = state_d != IDLE;
      dc_en_d    = state_d == DC;
      ac_en_d    = state_d == AC;
      idct_en_d  = state_d == IDCT;
      done_d     = state_d == DONE;
      drain_d    = (state_q == DC_DRAIN && state_d == DC_DRAIN) ? drain_q + 32'd1 : 32'd0;
      dc_cnt_d   = (state_q == DC && state_d == DC) ? dc_cnt_q + 32'd1 : 32'd0;
      ac_cnt_d   = (state_q == AC && state_d == AC) ? ac_cnt_q + 32'd1 : 32'd0;
      idct_cnt_d = (state_q == IDCT && state_d == IDCT) ? idct_cnt_q + 32'd1 : 32'd0;
      seq_d      = (state_q == IDLE || state_d == IDLE) ? 32'd0 : seq_q + 32'd1;
   end
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         nb_q       <= '0;
         drain_q    <= '0;
         dc_cnt_q   <= '0;
         ac_cnt_q   <= '0;
         idct_cnt_q <= '0;
         seq_q      <= '0;
         busy_q     <= 1'b0;
         dc_en_q    <= 1'b0;
         ac_en_q    <= 1'b0;
         idct_en_q  <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         tmo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         nb_q       <= nb_d;
         drain_q    <= drain_d;
         dc_cnt_q   <= dc_cnt_d;
         ac_cnt_q   <= ac_cnt_d;
         idct_cnt_q <= idct_cnt_d;
         seq_q      <= seq_d;
         busy_q     <= busy_d;
         dc_en_q    <= dc_en_d;
         ac_en_q    <= ac_en_d;
         idct_en_q  <= idct_en_d;
         done_q     <= done_d;
         ovr_q      <= ovr_d;
         tmo_q      <= tmo_d;
      end
   end
   assign busy             = busy_q;
   assign dc_vld_enable    = dc_en_q;
   assign dc_vld_counter   = dc_cnt_q;
   assign ac_vld_enable    = ac_en_q;
   assign ac_vld_counter   = ac_cnt_q;
   assign idct_enable      = idct_en_q;
   assign idct_counter     = idct_cnt_q;
   assign slice_done       = done_q;
   assign slice_overrun    = ovr_q;
   assign ac_timeout       = tmo_q;
   assign sequence_counter = seq_q;
endmodule

// File: tb/tb_slice_decode_sequencer.sv
// tb_slice_decode_sequencer: directed scenarios with hand-derived cycle timelines.
module tb_slice_decode_sequencer;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        slice_start = 1'b0;
   logic [31:0] block_num = '0;
   logic        ac_vld_done = 1'b0;
   logic        busy, dc_vld_enable, ac_vld_enable, idct_enable, slice_done, slice_overrun, ac_timeout;
   logic [31:0] dc_vld_counter, ac_vld_counter, idct_counter, sequence_counter;
   int          errors = 0;
   int          checks = 0;
   logic [134:0] obs, exp_v;

   slice_decode_sequencer dut (
      .clock(clock), .reset_n(reset_n), .slice_start(slice_start), .block_num(block_num),
      .ac_vld_done(ac_vld_done), .busy(busy), .dc_vld_enable(dc_vld_enable),
      .dc_vld_counter(dc_vld_counter), .ac_vld_enable(ac_vld_enable), .ac_vld_counter(ac_vld_counter),
      .idct_enable(idct_enable), .idct_counter(idct_counter), .slice_done(slice_done),
      .slice_overrun(slice_overrun), .ac_timeout(ac_timeout), .sequence_counter(sequence_counter)
   );

   always #5 clock = ~clock;

   assign obs = {busy, dc_vld_enable, ac_vld_enable, idct_enable, slice_done, slice_overrun, ac_timeout,
                 dc_vld_counter, ac_vld_counter, idct_counter, sequence_counter};

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL reset_state got=%h want=0", obs); end
      reset_n = 1'b1;
      tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL idle_after_reset got=%h want=0", obs); end
   endtask

   // 4 blocks: DC 1-4, drain 5-6, AC 7-20, IDCT 21-36, DONE 37, IDLE 38
   task automatic test_nominal;
      logic b, d, a, i, dn;
      block_num = 32'd4;
      slice_start = 1'b1;
      for (int c = 1; c <= 38; c++) begin
         tick();
         slice_start = 1'b0;
         ac_vld_done = (c == 20);
         d = c >= 1 && c <= 4; a = c >= 7 && c <= 20; i = c >= 21 && c <= 36; dn = c == 37; b = c <= 37;
         exp_v = {b, d, a, i, dn, 1'b0, 1'b0, d ? 32'(c - 1) : 32'd0, a ? 32'(c - 7) : 32'd0,
                  i ? 32'(c - 21) : 32'd0, b ? 32'(c - 1) : 32'd0};
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL nominal_c%0d got=%h want=%h", c, obs, exp_v); end
      end
      ac_vld_done = 1'b0;
   endtask

   task automatic test_timeout;
      block_num = 32'd4;
      slice_start = 1'b1;
      for (int c = 1; c <= 276; c++) begin
         tick();
         slice_start = 1'b0;
         if (c == 258) begin
            checks++;
            if ({ac_vld_enable, ac_timeout, ac_vld_counter} !== {2'b10, 32'd251}) begin
               errors++; $display("FAIL timeout_last_ac got=%b%b/%0d want=10/251", ac_vld_enable, ac_timeout, ac_vld_counter);
            end
         end
         if (c == 259) begin
            checks++;
            if ({ac_vld_enable, idct_enable, ac_timeout} !== 3'b011) begin
               errors++; $display("FAIL timeout_first_idct got=%b%b%b want=011", ac_vld_enable, idct_enable, ac_timeout);
            end
         end
      end
      checks++;
      if ({busy, ac_timeout} !== 2'b01) begin errors++; $display("FAIL timeout_sticky got=%b%b want=01", busy, ac_timeout); end
      block_num = 32'd1;
      slice_start = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         tick();
         slice_start = 1'b0;
         ac_vld_done = (c == 4);
         if (c == 1) begin
            checks++;
            if ({dc_vld_enable, ac_timeout} !== 2'b10) begin
               errors++; $display("FAIL timeout_cleared got=%b%b want=10", dc_vld_enable, ac_timeout);
            end
         end
      end
      ac_vld_done = 1'b0;
      checks++;
      if ({busy, ac_timeout} !== 2'b00) begin errors++; $display("FAIL timeout_second_slice got=%b%b want=00", busy, ac_timeout); end
   endtask

   // starts in AC (cycle 10) and DONE (cycle 37) are rejected; block_num change must not matter
   task automatic test_overrun;
      logic b, d, a, i, dn, o;
      block_num = 32'd4;
      slice_start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         tick();
         slice_start = (c == 10 || c == 37);
         block_num = 32'd7;
         ac_vld_done = (c == 20);
         d = c >= 1 && c <= 4; a = c >= 7 && c <= 20; i = c >= 21 && c <= 36; dn = c == 37; b = c <= 37;
         o = c == 11 || c == 38;
         exp_v = {b, d, a, i, dn, o, 1'b0, d ? 32'(c - 1) : 32'd0, a ? 32'(c - 7) : 32'd0,
                  i ? 32'(c - 21) : 32'd0, b ? 32'(c - 1) : 32'd0};
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL overrun_c%0d got=%h want=%h", c, obs, exp_v); end
      end
      ac_vld_done = 1'b0;
   endtask

   task automatic test_zero_block;
      block_num = 32'd0;
      slice_start = 1'b1;
      tick();
      slice_start = 1'b0;
      checks++;
      if ({busy, slice_overrun, dc_vld_enable} !== 3'b010) begin
         errors++; $display("FAIL zero_block_pulse got=%b%b%b want=010", busy, slice_overrun, dc_vld_enable);
      end
      tick();
      checks++;
      if ({busy, slice_overrun} !== 2'b00) begin errors++; $display("FAIL zero_block_after got=%b%b want=00", busy, slice_overrun); end
   endtask

   task automatic test_mid_reset;
      logic b, d, a, i, dn;
      block_num = 32'd4;
      slice_start = 1'b1;
      for (int c = 1; c <= 25; c++) begin
         tick();
         slice_start = 1'b0;
         ac_vld_done = (c == 20);
      end
      ac_vld_done = 1'b0;
      checks++;
      if ({idct_enable, idct_counter} !== {1'b1, 32'd4}) begin
         errors++; $display("FAIL mid_reset_pre got=%b/%0d want=1/4", idct_enable, idct_counter);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL mid_reset_async got=%h want=0", obs); end
      tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL mid_reset_held got=%h want=0", obs); end
      reset_n = 1'b1;
      tick();
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL mid_reset_released got=%h want=0", obs); end
      // 1 block: DC 1, drain 2-3, AC 4, IDCT 5-17, DONE 18, IDLE 19
      block_num = 32'd1;
      slice_start = 1'b1;
      for (int c = 1; c <= 19; c++) begin
         tick();
         slice_start = 1'b0;
         ac_vld_done = (c == 4);
         d = c == 1; a = c == 4; i = c >= 5 && c <= 17; dn = c == 18; b = c <= 18;
         exp_v = {b, d, a, i, dn, 1'b0, 1'b0, 32'd0, 32'd0, i ? 32'(c - 5) : 32'd0, b ? 32'(c - 1) : 32'd0};
         checks++;
         if (obs !== exp_v) begin errors++; $display("FAIL post_reset_c%0d got=%h want=%h", c, obs, exp_v); end
      end
      ac_vld_done = 1'b0;
   endtask

   task automatic test_simultaneous;
      block_num = 32'd1;
      slice_start = 1'b1;
      for (int c = 1; c <= 81; c++) begin
         tick();
         slice_start = 1'b0;
         ac_vld_done = (c == 66);
         if (c == 66) begin
            checks++;
            if ({ac_vld_enable, ac_vld_counter} !== {1'b1, 32'd62}) begin
               errors++; $display("FAIL simul_last_ac got=%b/%0d want=1/62", ac_vld_enable, ac_vld_counter);
            end
         end
         if (c == 67) begin
            checks++;
            if ({idct_enable, ac_timeout, idct_counter} !== {2'b10, 32'd0}) begin
               errors++; $display("FAIL simul_idct got=%b%b/%0d want=10/0", idct_enable, ac_timeout, idct_counter);
            end
         end
         if (c == 80) begin
            checks++;
            if (slice_done !== 1'b1) begin errors++; $display("FAIL simul_done got=%b want=1", slice_done); end
         end
      end
      ac_vld_done = 1'b0;
      checks++;
      if ({busy, ac_timeout} !== 2'b00) begin errors++; $display("FAIL simul_idle got=%b%b want=00", busy, ac_timeout); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_overrun();
      test_zero_block();
      test_mid_reset();
      test_simultaneous();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/slice_decode_sequencer.md
SLICE_DECODE_SEQUENCER -- requirements
Module: slice_decode_sequencer

Interface
REQ-001 Parameter DC_VLD_LAT, default 2: DC VLD pipeline drain, in cycles, after the last DC enable.
REQ-002 Parameter IDCT_TIME, default 12: IDCT pipeline latency, in cycles, added to block_num.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 slice_start  in  1  one-cycle request to decode one slice.
REQ-006 block_num  in  32  number of 8x8 blocks in the slice; sampled only on an accepted slice_start.
REQ-007 ac_vld_done  in  1  AC VLD reports the end of the slice's AC coefficients.
REQ-008 busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-009 dc_vld_enable  out  1  DC VLD stage enable.
REQ-010 dc_vld_counter  out  32  DC block index.
REQ-011 ac_vld_enable  out  1  AC VLD stage enable.
REQ-012 ac_vld_counter  out  32  AC cycle index.
REQ-013 idct_enable  out  1  dequant/IDCT stage enable.
REQ-014 idct_counter  out  32  IDCT cycle index.
REQ-015 slice_done  out  1  one-cycle completion pulse.
REQ-016 slice_overrun  out  1  one-cycle pulse for a rejected slice_start.
REQ-017 ac_timeout  out  1  sticky; indicates the AC phase ended without ac_vld_done.
REQ-018 sequence_counter  out  32  cycles since acceptance; 0 in IDLE.

Function
REQ-019 FSM states: IDLE, DC, DC_DRAIN, AC, IDCT, DONE.
REQ-020 All outputs are registered, and each state's outputs are valid in the first cycle that state is occupied.
REQ-021 IDLE -> DC when slice_start=1 and block_num!=0.
- On that transition: latch block_num to nb and clear ac_timeout.
REQ-022 slice_start with block_num==0 in IDLE:
- No state change.
- slice_overrun pulses for one cycle.
REQ-023 DC state:
- dc_vld_enable=1 for exactly nb cycles.
- dc_vld_counter=0..nb-1.
- Then go to DC_DRAIN.
REQ-024 DC_DRAIN state:
- All enables are 0 for exactly DC_VLD_LAT cycles.
- Then go to AC.
- When DC_VLD_LAT==0, DC goes directly to AC.
REQ-025 AC state:
- ac_vld_enable=1.
- ac_vld_counter starts at 0 and increments each cycle.
REQ-026 AC exit on ac_vld_done=1:
- Sampled in the AC state only.
- The next cycle is IDCT.
REQ-027 AC exit on timeout:
- Applies when ac_vld_counter==63*nb-1 and ac_vld_done=0.
- The next cycle is IDCT, and ac_timeout is set.
- If ac_vld_done=1 at that same cycle, ac_vld_done wins and ac_timeout stays 0.
REQ-028 The 63*nb product is computed in 32 bits, modulo 2^32.
REQ-029 IDCT state:
- idct_enable=1 for exactly nb+IDCT_TIME cycles.
- idct_counter=0..nb+IDCT_TIME-1.
- Then go to DONE.
REQ-030 DONE state lasts exactly one cycle.
- In that cycle: slice_done=1, busy=1, all enables=0.
- Next state is IDLE.
REQ-031 A slice_start in any state other than IDLE is ignored, with a one-cycle slice_overrun pulse.
- This includes DONE; slice_start is not pipelined.
REQ-032 sequence_counter = 0 in the first DC cycle and +1 per cycle through DONE.
- It returns to 0 in IDLE.
- Wraps modulo 2^32.
REQ-033 When an enable is 0, its counter holds 0.
REQ-034 At most one of dc_vld_enable, ac_vld_enable, idct_enable is high in any cycle.
REQ-035 block_num changes after acceptance have no effect on the slice in progress.

Reset
REQ-036 reset_n=0 forces the following immediately, regardless of clock:
- State: IDLE.
- All enables, busy, slice_done, slice_overrun, ac_timeout: 0.
- All counters: 0.
- nb: 0.
REQ-037 Reset asserted mid-slice abandons the slice with no slice_done.
- After reset_n deasserts, the next slice_start is accepted normally.

Verification
REQ-038 Nominal slice; defaults, block_num=4, slice_start at cycle 0, ac_vld_done at cycle 20 ->
- dc_vld_enable in cycles 1-4 (counter 0-3).
- Drain in cycles 5-6.
- ac_vld_enable in cycles 7-20.
- idct_enable in cycles 21-36 (counter 0-15).
- slice_done in cycle 37; IDLE in cycle 38.
REQ-039 AC timeout; block_num=4, ac_vld_done never asserted ->
- AC lasts 252 cycles (counter 0-251).
- ac_timeout=1 from the first IDCT cycle.
- ac_timeout clears on the next accepted slice_start.
REQ-040 Overrun; slice_start pulsed during AC and again during DONE ->
- Two slice_overrun pulses.
- The first slice completes with unchanged timing.
- No second slice starts.
REQ-041 Zero-block slice; slice_start with block_num=0 in IDLE -> slice_overrun=1 for one cycle, busy stays 0.
REQ-042 Mid-slice reset; reset_n pulsed low in IDCT cycle 5 of a slice ->
- All outputs are 0 while reset_n=0, with no slice_done.
- A subsequent slice with block_num=1, ac_vld_done at the first AC cycle, gives dc_vld_enable for 1 cycle, AC 1 cycle, IDCT 13 cycles, then slice_done.
REQ-043 Simultaneous ac_vld_done and timeout; block_num=1, ac_vld_done at ac_vld_counter=62 -> IDCT entered next cycle with ac_timeout=0.
